// File: rtl/mul_add_skid_stage.sv
// Elastic boundary between the partial-multiply and addition stages of the pipelined
// FP multiplier: valid/ready on both sides, main + skid registers, strict FIFO order.
module mul_add_skid_stage #(
    parameter int W_SUM  = 40,
    parameter int W_FRAC = 23,
    parameter int W_EXP  = 10
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,

    input  logic              m_valid,
    output logic              m_ready,
    input  logic [1:0]        m_rm,
    input  logic              m_sign,
    input  logic [W_EXP-1:0]  m_exp10,
    input  logic              m_is_nan,
    input  logic              m_is_inf,
    input  logic [W_FRAC-1:0] m_inf_nan_frac,
    input  logic [W_SUM-1:0]  m_sum,
    input  logic [W_SUM-1:0]  m_carry,
    input  logic [7:0]        m_z8,

    output logic              a_valid,
    input  logic              a_ready,
    output logic [1:0]        a_rm,
    output logic              a_sign,
    output logic [W_EXP-1:0]  a_exp10,
    output logic              a_is_nan,
    output logic              a_is_inf,
    output logic [W_FRAC-1:0] a_inf_nan_frac,
    output logic [W_SUM-1:0]  a_sum,
    output logic [W_SUM-1:0]  a_carry,
    output logic [7:0]        a_z8,
    output logic [1:0]        a_count
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]        rm;
        logic              sign;
        logic [W_EXP-1:0]  exp10;
        logic              is_nan;
        logic              is_inf;
        logic [W_FRAC-1:0] frac;
        logic [W_SUM-1:0]  sum;
        logic [W_SUM-1:0]  carry;
        logic [7:0]        z8;
    } beat_t;

    state_t state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  m_beat;
    logic   acc, pop;

    assign m_beat = {m_rm, m_sign, m_exp10, m_is_nan, m_is_inf,
                     m_inf_nan_frac, m_sum, m_carry, m_z8};

    // Handshake outputs depend on the state register alone.
    assign m_ready = (state_q != FULL);
    assign a_valid = (state_q != EMPTY);
    assign a_count = state_q;

    assign acc = m_valid & m_ready;
    assign pop = a_valid & a_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = m_beat;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = m_beat;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = m_beat;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign a_rm           = main_q.rm;
    assign a_sign         = main_q.sign;
    assign a_exp10        = main_q.exp10;
    assign a_is_nan       = main_q.is_nan;
    assign a_is_inf       = main_q.is_inf;
    assign a_inf_nan_frac = main_q.frac;
    assign a_sum          = main_q.sum;
    assign a_carry        = main_q.carry;
    assign a_z8           = main_q.z8;

endmodule

// File: tb/tb_mul_add_skid_stage.sv
// Bench for mul_add_skid_stage: table of handshake vectors plus a queue scoreboard
// holding the beats the stage is expected to present, in order.
module tb_mul_add_skid_stage;

    localparam int W_SUM  = 40;
    localparam int W_FRAC = 23;
    localparam int W_EXP  = 10;

    typedef struct packed {
        logic [1:0]        rm;
        logic              sign;
        logic [W_EXP-1:0]  exp10;
        logic              is_nan;
        logic              is_inf;
        logic [W_FRAC-1:0] frac;
        logic [W_SUM-1:0]  sum;
        logic [W_SUM-1:0]  carry;
        logic [7:0]        z8;
    } beat_t;

    typedef struct {
        logic             mv;
        logic             ar;
        logic             fl;
        logic [W_SUM-1:0] sum_i;
        int               cnt;
        logic [W_SUM-1:0] sum_o;
    } vec_t;

    logic              clk = 1'b0;
    logic              clrn, flush, m_valid, m_ready, a_valid, a_ready;
    beat_t             m_b, a_b;
    logic [1:0]        a_rm;
    logic              a_sign, a_is_nan, a_is_inf;
    logic [W_EXP-1:0]  a_exp10;
    logic [W_FRAC-1:0] a_inf_nan_frac;
    logic [W_SUM-1:0]  a_sum, a_carry;
    logic [7:0]        a_z8;
    logic [1:0]        a_count;

    beat_t q[$];
    vec_t  tbl[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mul_add_skid_stage #(.W_SUM(W_SUM), .W_FRAC(W_FRAC), .W_EXP(W_EXP)) dut (
        .clk(clk), .clrn(clrn), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_rm(m_b.rm), .m_sign(m_b.sign), .m_exp10(m_b.exp10),
        .m_is_nan(m_b.is_nan), .m_is_inf(m_b.is_inf), .m_inf_nan_frac(m_b.frac),
        .m_sum(m_b.sum), .m_carry(m_b.carry), .m_z8(m_b.z8),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_rm(a_rm), .a_sign(a_sign), .a_exp10(a_exp10),
        .a_is_nan(a_is_nan), .a_is_inf(a_is_inf), .a_inf_nan_frac(a_inf_nan_frac),
        .a_sum(a_sum), .a_carry(a_carry), .a_z8(a_z8),
        .a_count(a_count)
    );

    assign a_b = {a_rm, a_sign, a_exp10, a_is_nan, a_is_inf,
                  a_inf_nan_frac, a_sum, a_carry, a_z8};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [W_SUM-1:0] s);
        beat_t b;
        b.rm     = s[1:0];
        b.sign   = s[0];
        b.exp10  = s[9:0] ^ 10'h155;
        b.is_nan = s[1];
        b.is_inf = s[2];
        b.frac   = s[22:0] ^ 23'h2AAAAA;
        b.sum    = s;
        b.carry  = ~s;
        b.z8     = s[7:0] + 8'h3C;
        return b;
    endfunction

    function automatic beat_t rnd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[125:0];
    endfunction

    function automatic void add(input logic mv, input logic ar, input logic fl,
                                input logic [W_SUM-1:0] si, input int cnt,
                                input logic [W_SUM-1:0] so);
        vec_t v;
        v.mv = mv; v.ar = ar; v.fl = fl; v.sum_i = si; v.cnt = cnt; v.sum_o = so;
        tbl.push_back(v);
    endfunction

    // One clock: check status and head against the model, drive inputs, update the model.
    task automatic cycle(input logic mv, input logic ar, input logic fl, input beat_t b);
        int n;
        bit acc, pop;
        @(negedge clk);
        n = q.size();
        chk("status", 128'({a_valid, m_ready, a_count}), 128'({n != 0, n < 2, 2'(n)}));
        if (n > 0) chk("head", 128'(a_b), 128'(q[0]));
        m_valid = mv; a_ready = ar; flush = fl; m_b = b;
        acc = mv && (n < 2);
        pop = ar && (n > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_status"}, 128'({a_valid, m_ready, a_count}), 128'(4'b0100));
        chk({name, "_sum"}, 128'(a_sum), 128'(0));
        chk({name, "_exp"}, 128'(a_exp10), 128'(0));
    endtask

    initial begin
        beat_t sp;

        // streaming 1..8
        for (int i = 1; i <= 8; i++) add(1, 1, 0, W_SUM'(i), 1, W_SUM'(i));
        add(0, 1, 0, 0, 0, 0);
        // back-pressure 0xA, 0xB; 0xC refused while full
        add(1, 0, 0, 'hA, 1, 'hA);
        add(1, 0, 0, 'hB, 2, 'hA);
        add(1, 0, 0, 'hC, 2, 'hA);
        add(0, 1, 0, 0, 1, 'hB);
        add(0, 1, 0, 0, 0, 0);
        // simultaneous accept and pop in ONE
        add(1, 0, 0, 'h5, 1, 'h5);
        add(1, 1, 0, 'h6, 1, 'h6);
        add(0, 1, 0, 0, 0, 0);
        // flush in FULL with a beat offered, flush in EMPTY, flush in ONE
        add(1, 0, 0, 'h11, 1, 'h11);
        add(1, 0, 0, 'h12, 2, 'h11);
        add(1, 1, 1, 'h13, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 'h14, 0, 0);
        add(1, 0, 0, 'h20, 1, 'h20);
        add(1, 0, 1, 'h21, 0, 0);
        add(1, 1, 0, 'h30, 1, 'h30);
        add(0, 1, 0, 0, 0, 0);

        // reset with random inputs, then release
        clrn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_b = rnd(); m_valid = 1'($urandom()); a_ready = 1'($urandom()); flush = 1'($urandom());
            @(posedge clk);
            #1;
            chk_zero("rst");
        end
        @(negedge clk);
        m_valid = 1'b0; a_ready = 1'b0; flush = 1'b0;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_rel");

        foreach (tbl[i]) begin
            cycle(tbl[i].mv, tbl[i].ar, tbl[i].fl, mk(tbl[i].sum_i));
            #1;
            chk($sformatf("tbl%0d_cnt", i), 128'(a_count), 128'(tbl[i].cnt));
            if (tbl[i].cnt != 0)
                chk($sformatf("tbl%0d_sum", i), 128'(a_sum), 128'(tbl[i].sum_o));
        end

        // special-case payload passes verbatim
        sp = '0;
        sp.is_nan = 1'b1; sp.frac = 23'h400000; sp.rm = 2'b11; sp.z8 = 8'hFF;
        sp.sign = 1'b1; sp.exp10 = 10'h3FF; sp.sum = 40'hFF_0000_0001; sp.carry = 40'h80_1234_5678;
        cycle(1, 1, 0, sp);
        #1;
        chk("spec_beat", 128'(a_b), 128'(sp));
        chk("spec_nan", 128'(a_is_nan), 128'(1));
        chk("spec_frac", 128'(a_inf_nan_frac), 128'(23'h400000));
        chk("spec_rm_z8", 128'({a_rm, a_z8}), 128'(10'h3FF));
        cycle(0, 1, 0, mk(0));

        // randomized traffic with occasional flush
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom()), 1'($urandom()), ($urandom_range(0, 15) == 0), rnd());
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, rnd());

        // reset while full: outputs clear without waiting for a clock edge
        cycle(1, 0, 0, mk('h40));
        cycle(1, 0, 0, mk('h41));
        @(negedge clk);
        m_valid = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        chk_zero("rst_mid");
        q.delete();
        @(negedge clk);
        clrn = 1'b1;
        cycle(0, 1, 0, mk(0));
        cycle(0, 0, 0, mk(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
